// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes engine: LANES shared S-box pairs sweep the 16-byte state in 16/LANES chunks.
// Optional macro SUB_BYTES_ITER_REG_SBOX_EN registers the lane outputs (one extra BUSY cycle).
module sub_bytes_iter #(
    parameter int LANES   = 4,
    parameter int STATE_W = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    localparam int NCHUNK = 16 / LANES;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end
    if (STATE_W != 128) begin : g_bad_width
        $error("sub_bytes_iter: STATE_W must be 128");
    end

    // GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1; the S-boxes are built from it rather than stored.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse for x != 0 and maps 0 to 0, as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e             fsm_q;
    logic [127:0]       data_q;
    logic [127:0]       data_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               inv_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               accept;
    logic [7:0]         lane_in  [LANES];
    logic [7:0]         lane_out [LANES];
`ifdef SUB_BYTES_ITER_REG_SBOX_EN
    logic [7:0]         pipe_q   [LANES];
    logic [CNT_W-1:0]   pipe_idx_q;
    logic               pipe_vld_q;
    logic               look_done_q;
`endif

    assign in_ready  = (fsm_q == S_IDLE) || ((fsm_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = data_q;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l]  = data_q[8*(int'(cnt_q)*LANES + l) +: 8];
            lane_out[l] = inv_q ? inv_sbox(lane_in[l]) : fwd_sbox(lane_in[l]);
        end
    end

    // NOTE: data_d starts from data_q so every byte outside the current chunk holds; no latch is possible.
    always_comb begin
        data_d = data_q;
        for (int l = 0; l < LANES; l++) begin
`ifdef SUB_BYTES_ITER_REG_SBOX_EN
            data_d[8*(int'(pipe_idx_q)*LANES + l) +: 8] = pipe_q[l];
`else
            data_d[8*(int'(cnt_q)*LANES + l) +: 8] = lane_out[l];
`endif
        end
    end

    // NOTE: the state register is reset too, because out_state must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= S_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SUB_BYTES_ITER_REG_SBOX_EN
            pipe_q      <= '{default: 8'h00};
            pipe_idx_q  <= '0;
            pipe_vld_q  <= 1'b0;
            look_done_q <= 1'b0;
`endif
        end else begin
            case (fsm_q)
                S_BUSY: begin
`ifdef SUB_BYTES_ITER_REG_SBOX_EN
                    if (!look_done_q) begin
                        pipe_q      <= lane_out;
                        pipe_idx_q  <= cnt_q;
                        pipe_vld_q  <= 1'b1;
                        cnt_q       <= cnt_q + 1'b1;
                        look_done_q <= (cnt_q == LAST);
                    end else begin
                        pipe_vld_q  <= 1'b0;
                    end
                    if (pipe_vld_q) begin
                        data_q <= data_d;
                        if (pipe_idx_q == LAST) begin
                            fsm_q       <= S_DONE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
`else
                    data_q <= data_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        fsm_q       <= S_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        fsm_q       <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
            // A new accept (from IDLE, or back-to-back out of DONE) overrides the updates above.
            if (accept) begin
                fsm_q  <= S_BUSY;
                busy_q <= 1'b1;
                data_q <= in_state;
                inv_q  <= in_inv;
                cnt_q  <= '0;
`ifdef SUB_BYTES_ITER_REG_SBOX_EN
                pipe_vld_q  <= 1'b0;
                look_done_q <= 1'b0;
`endif
            end
        end
    end

endmodule
